// File: rtl/cpu_req_queue_if.sv
// cpu_req_queue_if: producer handshake (request/response) and L1 CPU port
// bundled for cpu_req_queue. The slave modport is the queue itself; the
// master modport is the side that produces requests and models the L1.
interface cpu_req_queue_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_data_in;
  logic                  cpu_read;
  logic                  cpu_write;
  logic [DATA_WIDTH-1:0] cpu_data_out;
  logic                  cpu_ready;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           cpu_data_out, cpu_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_addr, rsp_rdata,
           cpu_addr, cpu_data_in, cpu_read, cpu_write
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           cpu_data_out, cpu_ready,
    output req_ready, rsp_valid, rsp_write, rsp_addr, rsp_rdata,
           cpu_addr, cpu_data_in, cpu_read, cpu_write
  );
endinterface

// File: rtl/cpu_req_queue.sv
// cpu_req_queue: request FIFO in front of the L1 CPU port. Each queued
// request is replayed as a one-cycle strobe, the L1 completion is awaited
// (ignoring cpu_ready for one settle cycle) and the result is held on the
// response handshake. One L1 access is outstanding at a time.
// Optional feature macro: CPU_REQ_TIMEOUT_EN (bounds the L1 wait and sets
// the sticky timeout_err flag).
module cpu_req_queue #(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  cpu_req_queue_if.slave                   bus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
  output logic                             busy,
  output logic                             timeout_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH;

`ifdef CPU_REQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] cpu_addr_q, cpu_addr_d, rsp_addr_q, rsp_addr_d;
  logic [DATA_WIDTH-1:0] cpu_data_q, cpu_data_d, rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_write_q, rsp_write_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic                  full, empty, push, pop, tmo_hit;
  logic [ENT_W-1:0]      head;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push    = bus.req_valid && !full;
  assign pop     = (state_q == S_IDLE) && !empty;
  assign head    = mem_q[rd_ptr_q];
  // The counter holds the SETTLE/WAIT cycles already spent; the limit is
  // hit on the WAIT cycle whose increment would reach TIMEOUT_CYCLES.
  assign tmo_hit = TMO_EN && (tmo_q >= TMO_W'(TIMEOUT_CYCLES - 1));

  // FIFO storage: payload only, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.req_write, bus.req_addr, bus.req_wdata};
    end
  end

  // FIFO pointers and occupancy; power-of-two depth wraps naturally.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Access sequencer: next state plus the registered address/data/response.
  always_comb begin
    state_d       = state_q;
    cpu_addr_d    = cpu_addr_q;
    cpu_data_d    = cpu_data_q;
    rsp_addr_d    = rsp_addr_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    timeout_err_d = timeout_err_q;
    tmo_d         = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          rsp_write_d = head[ENT_W-1];
          cpu_addr_d  = head[DATA_WIDTH +: ADDR_WIDTH];
          rsp_addr_d  = head[DATA_WIDTH +: ADDR_WIDTH];
          cpu_data_d  = head[DATA_WIDTH-1:0];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        // cpu_ready may still reflect the previous access here.
        tmo_d   = tmo_q + TMO_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (bus.cpu_ready) begin
          rsp_rdata_d = rsp_write_q ? '0 : bus.cpu_data_out;
          state_d     = S_RESP;
        end else if (tmo_hit) begin
          rsp_rdata_d   = '0;
          timeout_err_d = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards the queue and any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cpu_addr_q    <= '0;
      cpu_data_q    <= '0;
      rsp_addr_q    <= '0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      timeout_err_q <= 1'b0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      cpu_addr_q    <= cpu_addr_d;
      cpu_data_q    <= cpu_data_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      timeout_err_q <= timeout_err_d;
      tmo_q         <= tmo_d;
    end
  end

  assign bus.req_ready   = !full;
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_write   = rsp_write_q;
  assign bus.rsp_addr    = rsp_addr_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.cpu_addr    = cpu_addr_q;
  assign bus.cpu_data_in = cpu_data_q;
  // Strobes are decoded from ISSUE only, so they can never overlap.
  assign bus.cpu_read    = (state_q == S_ISSUE) && !rsp_write_q;
  assign bus.cpu_write   = (state_q == S_ISSUE) &&  rsp_write_q;
  assign count           = count_q;
  assign busy            = (state_q != S_IDLE);
  assign timeout_err     = timeout_err_q;

endmodule

// File: doc/cpu_req_queue.md
# cpu_req_queue

CPU-side request queue sitting directly upstream of the L1 cache. Accepts read/write requests from a producer over a valid/ready handshake and buffers them in a small FIFO. Replays each request to the L1 CPU port as a one-cycle strobe, waits for `cpu_ready`, and returns the outcome to the producer over a held response handshake. Exactly one L1 access is outstanding at a time.

## Interface
- `ADDR_WIDTH`, 11: address width; matches the L1 `cpu_addr` width.
- `DATA_WIDTH`, 8: data width.
- `FIFO_DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 255: cycle limit for the L1 wait; used only with `CPU_REQ_TIMEOUT_EN`.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: producer request valid.
- `req_ready` out 1: FIFO not full.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_WIDTH: request address.
- `req_wdata` in DATA_WIDTH: write data.
- `rsp_valid` out 1: response valid; held until accepted.
- `rsp_ready` in 1: producer accepts the response.
- `rsp_write` out 1: echo of the request type.
- `rsp_addr` out ADDR_WIDTH: echo of the request address.
- `rsp_rdata` out DATA_WIDTH: read data; 0 for writes and for timed-out accesses.
- `cpu_addr` out ADDR_WIDTH: address to L1.
- `cpu_data_in` out DATA_WIDTH: write data to L1.
- `cpu_read` out 1: read strobe to L1.
- `cpu_write` out 1: write strobe to L1.
- `cpu_data_out` in DATA_WIDTH: read data from L1.
- `cpu_ready` in 1: L1 completion.
- `count` out $clog2(FIFO_DEPTH+1): FIFO occupancy.
- `busy` out 1: FSM is not in IDLE.
- `timeout_err` out 1: sticky timeout flag.

## Operation
- FIFO
  - Push occurs when `req_valid && req_ready`. `req_ready = (count != FIFO_DEPTH)`.
  - When full, a push is refused even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves `count` unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions
  - IDLE: if the FIFO is non-empty, pop the head, load `cpu_addr`, `cpu_data_in`, `rsp_addr`, and `rsp_write`, then go to ISSUE.
  - ISSUE: drive `cpu_read = !write` or `cpu_write = write` for exactly this one cycle, then go to SETTLE.
  - SETTLE: strobes low and `cpu_ready` ignored for one cycle, because L1 may still show ready from the previous access. Then go to WAIT.
  - WAIT: when `cpu_ready` is sampled 1, set `rsp_rdata` to `cpu_data_out` for a read or 0 for a write, set `rsp_valid = 1`, and go to RESP.
  - RESP: when `rsp_ready` is sampled 1, clear `rsp_valid` and go to IDLE.
- `cpu_addr` and `cpu_data_in` are stable from ISSUE through WAIT and keep their last values afterwards.
- `cpu_read` and `cpu_write` are never both 1.
- Reset mid-operation:
  - All state clears at the reset edge and the FIFO contents are discarded.
  - Strobes are 0 from the next cycle.
  - An in-flight L1 access is abandoned; no response is produced for it.

## Timing
- Reset values: `req_ready` 1; `count` 0; `busy` 0. All other outputs are 0.
- Push into an empty FIFO at edge E0 gives:
  - pop and ISSUE at E1, with the strobe high between E1 and E2;
  - SETTLE at E2 and WAIT at E3;
  - with `cpu_ready` sampled 1 at edge Ek (k ≥ 4), `rsp_valid` rises after Ek.
- `rsp_ready` already high gives `rsp_valid` high for exactly one cycle.
- Minimum period per request: 5 cycles, i.e. IDLE→ISSUE→SETTLE→WAIT→RESP.

## Configuration
- `CPU_REQ_TIMEOUT_EN` defined:
  - A counter clears on ISSUE and increments in SETTLE and WAIT.
  - When it reaches TIMEOUT_CYCLES without `cpu_ready`, the FSM goes to RESP with `rsp_rdata = 0` and sets `timeout_err`.
  - `timeout_err` stays set until `rst`.
- `CPU_REQ_TIMEOUT_EN` not defined: WAIT waits indefinitely and `timeout_err` is tied to 0.

## Test plan
- Reset: hold `rst` for 2 cycles → all outputs 0, `req_ready` 1, `count` 0.
- Single read to 0x004; L1 model returns 0x5A with `cpu_ready` 3 cycles after the strobe → exactly one `cpu_read` pulse, `cpu_addr` 0x004 held, then `rsp_valid` with `rsp_rdata` 0x5A and `rsp_addr` 0x004.
- Push 5 requests back-to-back (addresses 0x000, 0x002, 0x004, 0x006, 0x008) with `rsp_ready` 1 → `req_ready` drops when `count` = 4, the 5th request is accepted after the first pop, and responses return in order.
- Write 0x3C to 0x010 → one `cpu_write` pulse with `cpu_data_in` 0x3C; response has `rsp_write` 1 and `rsp_rdata` 0. With `rsp_ready` held 0 for 4 cycles, `rsp_valid` holds and no new strobe is issued.
- Assert `rst` during WAIT with 2 requests queued → `count` 0 and no strobe or response after reset. With `CPU_REQ_TIMEOUT_EN` and `cpu_ready` stuck at 0 → response arrives 255 cycles after ISSUE, `timeout_err` is 1 and stays sticky.
